// File: rtl/relu_pkg.sv
// relu_pkg: activation mode encodings and packed-lane slicing helper for relu_array_pipe
//   MODE_*  : 2-bit activation selects carried with each vector
//   lane_lo : LSB position of lane k in a bus packed at w bits per lane
package relu_pkg;

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// relu_lane: one lane's combinational activation and saturation slices
//   x_i    in  DATA_W  signed lane input
//   mode_i in  2       activation select
//   clip_i in  OUT_W   clipped-mode ceiling, treated as unsigned
//   y_o    out DATA_W  activation result (registered by the parent as S1)
//   s_i    in  DATA_W  registered activation result from S1
//   q_o    out OUT_W   saturated lane value (registered by the parent as S2)
//   sat_o  out 1       q_o was clamped
module relu_lane
    import relu_pkg::*;
#(
    parameter int DATA_W     = 21,
    parameter int OUT_W      = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  logic        [1:0]        mode_i,
    input  logic        [OUT_W-1:0]  clip_i,
    output logic signed [DATA_W-1:0] y_o,
    input  logic signed [DATA_W-1:0] s_i,
    output logic        [OUT_W-1:0]  q_o,
    output logic                     sat_o
);

    logic                     neg;
    logic signed [DATA_W-1:0] leaky;
    logic signed [DATA_W-1:0] clip_ext;
    logic        [DATA_W-OUT_W:0] hi;
    logic                     fits;

    assign neg      = x_i[DATA_W-1];
    assign leaky    = x_i >>> LEAK_SHIFT;
    assign clip_ext = DATA_W'(clip_i);

    always_comb begin
        y_o = x_i;
        case (mode_i)
            MODE_RELU:  y_o = neg ? '0 : x_i;
            MODE_LEAKY: y_o = neg ? leaky : x_i;
            MODE_CLIP:  y_o = neg ? '0 : (x_i > clip_ext ? clip_ext : x_i);
            MODE_PASS:  y_o = x_i;
        endcase
    end

    // The value fits in OUT_W when every bit from the OUT_W sign position upward agrees.
    assign hi    = s_i[DATA_W-1:OUT_W-1];
    assign fits  = (&hi) | ~(|hi);
    assign q_o   = fits ? s_i[OUT_W-1:0] : {s_i[DATA_W-1], {(OUT_W-1){~s_i[DATA_W-1]}}};
    assign sat_o = ~fits;

endmodule

// File: rtl/relu_array_pipe.sv
// relu_array_pipe: two-stage valid/ready activation + saturation over N_NEUR*N_IN lanes
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake; in_data packed DATA_W per lane, lane k at k*DATA_W
//   mode, clip_max      activation select and clip ceiling, sampled with each accepted vector
//   out_valid/out_ready output handshake; out_data packed OUT_W per lane
//   out_sat             at least one lane of out_data was clamped
//   vec_count           output handshakes since reset, wrapping
module relu_array_pipe
    import relu_pkg::*;
#(
    parameter int DATA_W     = 21,
    parameter int OUT_W      = 16,
    parameter int N_NEUR     = 4,
    parameter int N_IN       = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_NEUR*N_IN*DATA_W-1:0]   in_data,
    input  logic [1:0]                      mode,
    input  logic [OUT_W-1:0]                clip_max,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_NEUR*N_IN*OUT_W-1:0]    out_data,
    output logic                            out_sat,
    output logic [CNT_W-1:0]                vec_count
);

    localparam int LANES = N_NEUR * N_IN;

    logic [LANES*DATA_W-1:0] act_y;
    logic [LANES*OUT_W-1:0]  sat_y;
    logic [LANES-1:0]        sat_v;

    logic                    s1_valid_q, s1_valid_d;
    logic [LANES*DATA_W-1:0] s1_y_q, s1_y_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [LANES*OUT_W-1:0]  s2_data_q, s2_data_d;
    logic                    s2_sat_q, s2_sat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    s1_ready, s2_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        relu_lane #(
            .DATA_W     (DATA_W),
            .OUT_W      (OUT_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x_i    (in_data[lane_lo(k, DATA_W) +: DATA_W]),
            .mode_i (mode),
            .clip_i (clip_max),
            .y_o    (act_y[lane_lo(k, DATA_W) +: DATA_W]),
            .s_i    (s1_y_q[lane_lo(k, DATA_W) +: DATA_W]),
            .q_o    (sat_y[lane_lo(k, OUT_W) +: OUT_W]),
            .sat_o  (sat_v[k])
        );
    end

    // Activation is applied before S1, so mode/clip_max bind to their vector at acceptance.
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        s1_valid_d = s1_ready ? in_valid : s1_valid_q;
        s1_y_d     = (s1_ready && in_valid) ? act_y : s1_y_q;
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s2_data_d  = (s2_ready && s1_valid_q) ? sat_y : s2_data_q;
        s2_sat_d   = (s2_ready && s1_valid_q) ? |sat_v : s2_sat_q;
        cnt_d      = cnt_q + CNT_W'(s2_valid_q && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_relu_array_pipe.sv
// tb_relu_array_pipe: directed-vector bench for relu_array_pipe (CNT_W=4 to reach the wrap)
module tb_relu_array_pipe;

    localparam int DATA_W = 21;
    localparam int OUT_W  = 16;
    localparam int LANES  = 16;
    localparam int CNT_W  = 4;
    localparam int IW     = LANES * DATA_W;
    localparam int OW     = LANES * OUT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IW-1:0]    in_data = '0;
    logic [1:0]       mode = 2'b00;
    logic [OUT_W-1:0] clip_max = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OW-1:0]    out_data;
    logic             out_sat;
    logic [CNT_W-1:0] vec_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  exp_cnt = '0;

    relu_array_pipe #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .clip_max  (clip_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    // Every neuron gets the same four input values a,b,c,d.
    function automatic logic [IW-1:0] mk_in(input int a, input int b, input int c, input int d);
        int v[4];
        logic [IW-1:0] r;
        v = '{a, b, c, d};
        for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = DATA_W'(v[k%4]);
        return r;
    endfunction

    function automatic logic [OW-1:0] mk_out(input int a, input int b, input int c, input int d);
        int v[4];
        logic [OW-1:0] r;
        v = '{a, b, c, d};
        for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = OUT_W'(v[k%4]);
        return r;
    endfunction

    // Stream vector n: lane k holds n*16+k, non-negative and small so PASS leaves it unchanged.
    function automatic logic [IW-1:0] seq_in(input int n);
        logic [IW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = DATA_W'(n*16 + k);
        return r;
    endfunction

    function automatic logic [OW-1:0] seq_out(input int n);
        logic [OW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = OUT_W'(n*16 + k);
        return r;
    endfunction

    task automatic test_reset;
        #1;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (vec_count !== 4'd0) begin n_err++; $display("FAIL reset_vec_count got=%0d exp=0", vec_count); end
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b0;
        mode = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = seq_in(i + 1);
        end
        @(negedge clk); in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        if (vec_count !== 4'd0) begin n_err++; $display("FAIL midreset_vec_count got=%0d exp=0", vec_count); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL stale_vector cyc=%0d got=%b exp=0", i, out_valid); end
        end
        exp_cnt = 4'd0;
    endtask

    task automatic test_relu;
        @(negedge clk); in_valid = 1'b1; mode = 2'b00; in_data = mk_in(-5, 0, 7, (1 << 20) - 1);
        @(negedge clk); in_valid = 1'b0; #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL relu_early got=%b exp=0", out_valid); end
        @(negedge clk); #1;
        n_vec += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL relu_valid got=%b exp=1", out_valid); end
        if (out_data !== mk_out(0, 0, 7, 32767)) begin n_err++; $display("FAIL relu_data got=%h exp=%h", out_data, mk_out(0, 0, 7, 32767)); end
        if (out_sat !== 1'b1) begin n_err++; $display("FAIL relu_sat got=%b exp=1", out_sat); end
        exp_cnt++;
        @(negedge clk); #1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL relu_drain got=%b exp=0", out_valid); end
        if (vec_count !== exp_cnt) begin n_err++; $display("FAIL relu_count got=%0d exp=%0d", vec_count, exp_cnt); end
    endtask

    task automatic test_leaky;
        @(negedge clk); in_valid = 1'b1; mode = 2'b01; in_data = mk_in(-8, -1, -100, 9);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        n_vec += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL leaky_valid got=%b exp=1", out_valid); end
        if (out_data !== mk_out(-1, -1, -13, 9)) begin n_err++; $display("FAIL leaky_data got=%h exp=%h", out_data, mk_out(-1, -1, -13, 9)); end
        if (out_sat !== 1'b0) begin n_err++; $display("FAIL leaky_sat got=%b exp=0", out_sat); end
        exp_cnt++;
    endtask

    task automatic test_clip_modes;
        @(negedge clk); in_valid = 1'b1; mode = 2'b10; clip_max = 16'd6; in_data = mk_in(-3, 4, 6, 50);
        @(negedge clk); mode = 2'b11; clip_max = 16'd0; in_data = mk_in(-40000, 40000, 0, 1);
        @(negedge clk); mode = 2'b10; clip_max = 16'hFFFF; in_data = mk_in(50000, -1, 100, 0);
        #1;
        n_vec += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL clip_valid got=%b exp=1", out_valid); end
        if (out_data !== mk_out(0, 4, 6, 6)) begin n_err++; $display("FAIL clip_data got=%h exp=%h", out_data, mk_out(0, 4, 6, 6)); end
        if (out_sat !== 1'b0) begin n_err++; $display("FAIL clip_sat got=%b exp=0", out_sat); end
        @(negedge clk); in_valid = 1'b0; mode = 2'b00; #1;
        n_vec += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid got=%b exp=1", out_valid); end
        if (out_data !== mk_out(-32768, 32767, 0, 1)) begin n_err++; $display("FAIL pass_data got=%h exp=%h", out_data, mk_out(-32768, 32767, 0, 1)); end
        if (out_sat !== 1'b1) begin n_err++; $display("FAIL pass_sat got=%b exp=1", out_sat); end
        @(negedge clk); #1;
        n_vec += 2;
        if (out_data !== mk_out(32767, 0, 100, 0)) begin n_err++; $display("FAIL wideclip_data got=%h exp=%h", out_data, mk_out(32767, 0, 100, 0)); end
        if (out_sat !== 1'b1) begin n_err++; $display("FAIL wideclip_sat got=%b exp=1", out_sat); end
        exp_cnt += 4'd3;
        @(negedge clk); #1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL clip_drain got=%b exp=0", out_valid); end
        if (vec_count !== exp_cnt) begin n_err++; $display("FAIL clip_count got=%0d exp=%0d", vec_count, exp_cnt); end
    endtask

    task automatic test_backpressure;
        logic [3:0]    pat = 4'b1001;
        int            tx = 0, rx = 0, inflight = 0;
        logic          exp_rdy, prev_stall = 1'b0;
        logic [OW-1:0] prev_data = '0;
        mode = 2'b11;
        for (int cyc = 0; cyc < 80 && rx < 10; cyc++) begin
            @(negedge clk);
            out_ready = pat[cyc%4];
            in_valid  = (tx < 10);
            in_data   = seq_in(tx);
            #1;
            exp_rdy = !(inflight == 2 && !out_ready);
            n_vec++;
            if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, prev_data);
                end
            end
            if (out_valid) begin
                n_vec++;
                if (out_data !== seq_out(rx)) begin n_err++; $display("FAIL bp_order cyc=%0d got=%h exp=%h", cyc, out_data, seq_out(rx)); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin rx++; inflight--; exp_cnt++; end
            if (in_valid && exp_rdy) begin tx++; inflight++; end
        end
        n_vec++;
        if (rx != 10) begin n_err++; $display("FAIL bp_delivered got=%0d exp=10", rx); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
        n_vec++;
        if (vec_count !== exp_cnt) begin n_err++; $display("FAIL bp_count got=%0d exp=%0d", vec_count, exp_cnt); end
    endtask

    task automatic test_back_to_back_wrap;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mode = 2'b11; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = (i < 17);
            in_data  = seq_in(i + 50);
            #1;
            if (i < 17) begin
                n_vec++;
                if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
            end
            if (i >= 2 && i < 19) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== seq_out(i + 48)) begin
                    n_err++; $display("FAIL b2b_out cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, seq_out(i + 48));
                end
            end else begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle cyc=%0d got=%b exp=0", i, out_valid); end
            end
        end
        n_vec++;
        if (vec_count !== 4'd1) begin n_err++; $display("FAIL wrap_count got=%0d exp=1", vec_count); end
    endtask

    initial begin
        test_reset;
        test_relu;
        test_leaky;
        test_clip_modes;
        test_backpressure;
        test_back_to_back_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
